// File: rtl/write_ctrl.sv
// Producer-side controller for a two-slot ping-pong RAM. Writes go to slot 0/1
// in strict alternation. The reader frees a slot with a rising edge on r_done.
module write_ctrl #(
    parameter int   SIZE  = 8,
    parameter logic PUSH  = 1'b1,
    parameter int   CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  din,
    input  logic             write,
    input  logic [1:0]       r_done,
    output logic [SIZE-1:0]  w_data,
    output logic             w_addr,
    output logic             w_en,
    output logic [1:0]       status_vld,
    output logic             full,
    output logic             error,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [3:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_WRITING = 2'd1,
        S_VALID   = 2'd2
    } slot_state_t;

    slot_state_t r_state [2];
    slot_state_t w_next  [2];

    logic             r_w_ptr;
    logic [1:0]       r_done_prev;
    logic             r_w_en;
    logic             r_error;
    logic             r_w_addr;
    logic [SIZE-1:0]  r_w_data;
    logic [CNT_W-1:0] r_drop_cnt;

    logic       w_req;
    logic       w_accept;
    logic       w_reject;
    logic [1:0] w_release;

    // Acceptance looks at the pre-edge slot state, so a release and a write
    // to the same slot in one cycle still rejects the write.
    assign w_req     = (write == PUSH);
    assign w_accept  = w_req && (r_state[r_w_ptr] == S_FREE);
    assign w_reject  = w_req && (r_state[r_w_ptr] != S_FREE);
    assign w_release = r_done & ~r_done_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0] <= S_FREE;
            r_state[1] <= S_FREE;
        end else begin
            r_state[0] <= w_next[0];
            r_state[1] <= w_next[1];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_next[i] = r_state[i];
            case (r_state[i])
                S_FREE:    if (w_accept && (r_w_ptr == 1'(i))) w_next[i] = S_WRITING;
                S_WRITING: w_next[i] = S_VALID;
                S_VALID:   if (w_release[i]) w_next[i] = S_FREE;
                default:   w_next[i] = S_FREE;
            endcase
        end
    end

    always_comb begin
        status_vld[0] = (r_state[0] == S_VALID);
        status_vld[1] = (r_state[1] == S_VALID);
        full          = (r_state[0] != S_FREE) && (r_state[1] != S_FREE);
        dbg_state     = {r_state[1], r_state[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_ptr     <= 1'b0;
            r_done_prev <= 2'b00;
            r_w_en      <= 1'b0;
            r_error     <= 1'b0;
            r_w_addr    <= 1'b0;
            r_w_data    <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_done_prev <= r_done;
            r_w_en      <= w_accept;
            r_error     <= w_reject;
            if (w_accept) begin
                r_w_data <= din;
                r_w_addr <= r_w_ptr;
                r_w_ptr  <= ~r_w_ptr;
            end
            if (w_reject && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign w_en     = r_w_en;
    assign error    = r_error;
    assign w_addr   = r_w_addr;
    assign w_data   = r_w_data;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_write_ctrl.sv
// Bench for write_ctrl: a slot-occupancy reference model feeds an expected
// queue of write/drop events; a negedge monitor compares every DUT event.
module tb_write_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       write;
  logic [1:0] r_done;
  logic [7:0] w_data;
  logic       w_addr;
  logic       w_en;
  logic [1:0] status_vld;
  logic       full;
  logic       error;
  logic [7:0] drop_cnt;
  logic [3:0] dbg_state;

  write_ctrl #(.SIZE(8), .PUSH(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .write(write), .r_done(r_done),
    .w_data(w_data), .w_addr(w_addr), .w_en(w_en), .status_vld(status_vld),
    .full(full), .error(error), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_seen = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // expected event: {is_drop, addr, data}
  logic [9:0] exp_q[$];

  // reference model: a slot is occupied from accept until the reader's first
  // rising r_done edge after its data became visible (two edges after accept)
  int       edge_cnt = 0;
  bit       occ [2];
  int       rdy [2];
  bit       m_ptr;
  bit [1:0] m_prev;
  int       m_drops;
  bit [7:0] m_wdata;
  bit       m_waddr;
  bit [1:0] m_vld;

  always @(posedge clk) begin
    bit [1:0] rise;
    bit [1:0] vld_pre;
    edge_cnt++;
    if (rst) begin
      occ[0] = 0; occ[1] = 0; rdy[0] = 0; rdy[1] = 0;
      m_ptr = 0; m_prev = 0; m_drops = 0; m_wdata = 0; m_waddr = 0;
      exp_q.delete();
    end else begin
      rise   = r_done & ~m_prev;
      m_prev = r_done;
      for (int i = 0; i < 2; i++) vld_pre[i] = occ[i] && (edge_cnt >= rdy[i]);
      if (write) begin
        if (!occ[m_ptr]) begin
          exp_q.push_back({1'b0, m_ptr, din});
          occ[m_ptr] = 1;
          rdy[m_ptr] = edge_cnt + 2;
          m_wdata    = din;
          m_waddr    = m_ptr;
          m_ptr      = !m_ptr;
        end else begin
          exp_q.push_back({1'b1, 1'b0, 8'h00});
          if (m_drops < 255) m_drops++;
        end
      end
      for (int i = 0; i < 2; i++) if (vld_pre[i] && rise[i]) occ[i] = 0;
    end
    for (int i = 0; i < 2; i++) m_vld[i] = occ[i] && (edge_cnt >= rdy[i] - 1);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [9:0] e;
    if (mon_en) begin
      if (w_en) wen_seen++;
      if (w_en && error) check("wen_error_exclusive", 1, 0);
      if (w_en || error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, error, w_en}, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_is_drop", int'(error), int'(e[9]));
          if (!e[9]) begin
            check("w_addr_on_write", int'(w_addr), int'(e[8]));
            check("w_data_on_write", int'(w_data), int'(e[7:0]));
          end
        end
      end
      check("missing_event", exp_q.size(), 0);
      check("status_vld", int'(status_vld), int'(m_vld));
      check("full", int'(full), int'(occ[0] && occ[1]));
      check("drop_cnt", int'(drop_cnt), m_drops);
      check("w_data_hold", int'(w_data), int'(m_wdata));
      check("w_addr_hold", int'(w_addr), int'(m_waddr));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; write = 1'b0; r_done = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    din = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 8'h00; write = 1'b0; r_done = 2'b00;
    tick();
    mon_en = 1'b1;
    check("reset_w_en", int'(w_en), 0);
    check("reset_status", int'(status_vld), 0);
    do_reset();

    // single push
    push(8'hA5);
    check("t1_w_en", int'(w_en), 1);
    check("t1_w_addr", int'(w_addr), 0);
    check("t1_w_data", int'(w_data), 8'hA5);
    tick();
    check("t1_status", int'(status_vld), 1);
    check("t1_error", int'(error), 0);

    // fill both slots, then a dropped push
    do_reset();
    push(8'h11); tick();
    push(8'h22); tick();
    check("t2_status", int'(status_vld), 3);
    check("t2_full", int'(full), 1);
    push(8'h33);
    check("t2_error", int'(error), 1);
    check("t2_drop", int'(drop_cnt), 1);
    tick();

    // release slot 0, hold r_done, refill slot 0
    r_done = 2'b01; tick();
    check("t3_status", int'(status_vld), 2);
    repeat (5) tick();
    check("t3_hold", int'(status_vld), 2);
    push(8'h44); tick();
    check("t3_refill", int'(status_vld), 3);

    // release and push to the same slot in one cycle
    do_reset();
    push(8'h55); push(8'h66); tick();
    r_done = 2'b01; din = 8'h77; write = 1'b1;
    tick();
    check("t4_reject", int'(error), 1);
    tick();
    write = 1'b0;
    check("t4_accept", int'(w_en), 1);
    check("t4_addr", int'(w_addr), 0);
    tick();

    // held push saturates the drop counter
    do_reset();
    wen_seen = 0;
    din = 8'h88; write = 1'b1;
    repeat (300) tick();
    write = 1'b0;
    check("t5_drop_sat", int'(drop_cnt), 255);
    tick();
    check("t5_wen_pulses", wen_seen, 2);

    // reset right after an accepted push
    do_reset();
    push(8'h99);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_w_en", int'(w_en), 0);
    check("t6_status", int'(status_vld), 0);
    tick();
    push(8'hAA);
    check("t6_addr", int'(w_addr), 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 499) == 0);
      write = ($urandom_range(0, 99) < 40);
      din   = 8'($urandom_range(0, 255));
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 99) < 20) r_done[b] = ~r_done[b];
      tick();
    end
    rst = 1'b0; write = 1'b0;
    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/write_ctrl.md
Name: write_ctrl

Overview:
- Producer-side controller for the two-slot ping-pong dual-port RAM; the counterpart of the RAM read controller.
- Accepts debounced write pushes and issues RAM write strobes into slot 0/1 alternately.
- Publishes per-slot valid status to the reader and frees a slot when the reader reports it consumed (r_done).
- Flags and counts writes dropped because the target slot is still occupied.

Parameters:
- SIZE, 8, data width of din / w_data.
- PUSH, 1'b1, active level of the write push input.
- CNT_W, 8, width of the dropped-write counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  SIZE  data to store.
- write  input  1  write request; sampled every cycle, request when write==PUSH.
- r_done  input  2  reader's consumed flags (bit i = slot i), registered level from reader.
- w_data  output  SIZE  RAM write data.
- w_addr  output  1  RAM write address (slot).
- w_en  output  1  RAM write enable, one-cycle pulse.
- status_vld  output  2  bit i = slot i holds unread valid data.
- full  output  1  both slots non-FREE.
- error  output  1  one-cycle pulse: write request dropped.
- drop_cnt  output  CNT_W  saturating count of dropped writes.

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - w_data=0, w_addr=0, w_en=0, status_vld=2'b00, full=0, error=0, drop_cnt=0.
  - Internal w_ptr=0, both slot FSMs FREE, r_done history=2'b00.
  - Reset mid-operation discards any in-flight write; no w_en after reset.
- Per-slot FSM (i=0,1): FREE -> WRITING -> VALID -> FREE.
  - FREE->WRITING: write accepted with w_ptr==i.
  - WRITING->VALID: unconditionally, next cycle.
  - VALID->FREE: rising edge on r_done[i] (r_done[i]==1 and previous-cycle r_done[i]==0).
  - r_done edges seen by a slot in FREE or WRITING are ignored, with no error. A held-high r_done never frees the slot twice.
- Write accept: write==PUSH in cycle N and slot[w_ptr]==FREE (current state).
  - Cycle N+1: w_en=1, w_data=din as sampled in N, w_addr=slot; w_ptr toggles.
  - Cycle N+2: status_vld[slot]=1. The RAM write commits at the end of N+1, so the reader never sees valid before the data is written.
  - Write latency: request to valid = 2 cycles.
- Write reject: write==PUSH in cycle N and slot[w_ptr]!=FREE.
  - Cycle N+1: error=1, no w_en, w_ptr unchanged.
  - drop_cnt increments and saturates at all-ones.
- error and w_en are mutually exclusive and never high for two consecutive cycles from a single request. A push held for k cycles is k requests.
- w_data and w_addr hold their last values when w_en=0.
- status_vld[i]=1 iff slot i is in VALID; it is registered and has no combinational path from inputs.
- full=1 iff neither slot is FREE; it is derived from state registers only.
- Simultaneous events:
  - Release of slot[w_ptr] and a write in the same cycle: the write is rejected, because acceptance uses the pre-edge state.
  - Release of the other slot and a write in the same cycle: both take effect.
  - Releases of both slots in the same cycle: both slots go FREE.
- Order is strict alternation 0,1,0,1,... matching the reader's r_addr toggling. There is no skipping to a free slot out of order.

Test Plan:
- Reset, then a single push din=8'hA5 -> w_en=1, w_addr=0, w_data=A5 at N+1; status_vld=01 at N+2; full=0, error=0.
- Two pushes (din=11 then 22, two cycles apart), no r_done -> slot0=11, slot1=22; status_vld=11, full=1. A third push gives error=1 for one cycle, drop_cnt=1, no w_en.
- Both slots full, then r_done 00->01 -> status_vld=10 the next cycle. r_done held at 01 for 5 more cycles -> no further change. A push then writes slot 0 and status_vld returns to 11.
- Slot 0 VALID, w_ptr=0, r_done 00->01 and push in the same cycle -> push rejected (error=1, drop_cnt+1); a repeat push next cycle is accepted into slot 0.
- Hold write high for 300 cycles with r_done=00 -> exactly 2 w_en pulses, drop_cnt saturates at 8'hFF, error high on every dropped cycle.
- Assert rst in the cycle after an accepted push -> w_en stays 0 from the next edge, status_vld=00, drop_cnt=0, next accepted write goes to slot 0.
